// File: rtl/udp_mux_pkg.sv
// Shared types and constants for the UDP client multiplexer.
// Header delay, FSM encoding, destination-port byte offsets and a saturating counter helper.
package udp_mux_pkg;

    localparam int unsigned HDR_DLY = 5;
    localparam int unsigned GRANT_W = 3;

    localparam logic [2:0] DPORT_HI   = 3'd2;
    localparam logic [2:0] DPORT_LO   = 3'd3;
    localparam logic [2:0] DECIDE_IDX = 3'd4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StPay  = 2'd2,
        StSkip = 2'd3
    } mux_state_e;

    typedef struct packed {
        logic [10:0] len;
        logic [7:0]  data;
        logic        raw_l;
        logic        raw_s;
    } dly_word_t;

    localparam int unsigned DLY_W = $bits(dly_word_t);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/reg_delay.sv
// Fixed-depth register delay line with asynchronous clear.
// Output equals the input Depth cycles earlier; all stages reset to zero.
module reg_delay #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[Depth-1];

endmodule

// File: rtl/udp_client_mux.sv
// Shares one RTEFI UDP client slot among N_CL clients, selected by UDP destination port.
// Input stream is delayed by HDR_DLY so the port decision lands before the first delayed byte.
module udp_client_mux
    import udp_mux_pkg::*;
#(
    parameter int unsigned N_CL      = 4,
    parameter logic [15:0] PORT_BASE = 16'd3000,
    parameter int unsigned N_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       len_c,
    input  logic [7:0]        idata,
    input  logic              raw_l,
    input  logic              raw_s,
    input  logic [N_CL-1:0]   client_en,
    output logic [7:0]        odata,
    output logic [10:0]       len_o,
    output logic [7:0]        idata_o,
    output logic [N_CL-1:0]   raw_l_o,
    output logic [N_CL-1:0]   raw_s_o,
    input  logic [8*N_CL-1:0] odata_i,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    dly_word_t dly_in, dly_out;

    assign dly_in = '{len: len_c, data: idata, raw_l: raw_l, raw_s: raw_s};

    reg_delay #(
        .Width(DLY_W),
        .Depth(HDR_DLY)
    ) u_in_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (dly_in),
        .q    (dly_out)
    );

    mux_state_e         state_q, state_d;
    logic               raw_l_q;
    logic [2:0]         bi_q, bi_d;
    logic [15:0]        port_q, port_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic [15:0]        hit_cnt_q, hit_cnt_d;
    logic [15:0]        miss_cnt_q, miss_cnt_d;

    logic [15:0]        idx;
    logic               hit;
    logic [GRANT_W-1:0] hit_grant;

    always_comb begin
        idx       = port_q - PORT_BASE;
        hit       = 1'b0;
        hit_grant = '0;
        for (int unsigned k = 0; k < N_CL; k++) begin
            if (idx == 16'(k) && client_en[k]) begin
                hit       = 1'b1;
                hit_grant = GRANT_W'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bi_d        = bi_q;
        port_d      = port_q;
        grant_d     = grant_q;
        hit_pulse_d = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        if (raw_l) begin
            bi_d = (bi_q == 3'd7) ? bi_q : bi_q + 3'd1;
        end

        case (state_q)
            StIdle: begin
                if (raw_l && !raw_l_q) begin
                    state_d = StHdr;
                    bi_d    = 3'd1;
                end
            end
            StHdr: begin
                if (bi_q == DPORT_HI) port_d[15:8] = idata;
                if (bi_q == DPORT_LO) port_d[7:0]  = idata;
                if (bi_q == DECIDE_IDX) begin
                    if (hit) begin
                        grant_d     = hit_grant;
                        hit_pulse_d = 1'b1;
                        hit_cnt_d   = sat_inc(hit_cnt_q);
                        state_d     = StPay;
                    end else begin
                        miss_cnt_d  = sat_inc(miss_cnt_q);
                        state_d     = StSkip;
                    end
                    if (!raw_l) state_d = StIdle;
                end else if (!raw_l) begin
                    // Runt: header ended before the port was complete.
                    state_d = StIdle;
                end
            end
            StPay, StSkip: begin
                if (!raw_l) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output-side gate, re-latched on each delayed packet start. The decision pulse for a
    // packet lines up exactly with its first delayed byte, so a runt never inherits a grant.
    logic               raw_l_d_q;
    logic               out_hit_q, out_hit;
    logic [GRANT_W-1:0] out_grant_q, out_grant;
    logic               rise_d;

    assign rise_d    = dly_out.raw_l && !raw_l_d_q;
    assign out_hit   = rise_d ? hit_pulse_q : out_hit_q;
    assign out_grant = rise_d ? grant_q : out_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            // Held high so a packet already in flight at reset release is not seen as a start.
            raw_l_q     <= 1'b1;
            bi_q        <= 3'd0;
            port_q      <= 16'd0;
            grant_q     <= '0;
            hit_pulse_q <= 1'b0;
            hit_cnt_q   <= 16'd0;
            miss_cnt_q  <= 16'd0;
            raw_l_d_q   <= 1'b0;
            out_hit_q   <= 1'b0;
            out_grant_q <= '0;
        end else begin
            state_q     <= state_d;
            raw_l_q     <= raw_l;
            bi_q        <= bi_d;
            port_q      <= port_d;
            grant_q     <= grant_d;
            hit_pulse_q <= hit_pulse_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            raw_l_d_q   <= dly_out.raw_l;
            out_hit_q   <= out_hit;
            out_grant_q <= out_grant;
        end
    end

    always_comb begin
        raw_l_o = '0;
        raw_s_o = '0;
        for (int unsigned k = 0; k < N_CL; k++) begin
            if (out_hit && out_grant == GRANT_W'(k)) begin
                raw_l_o[k] = dly_out.raw_l;
                raw_s_o[k] = dly_out.raw_s;
            end
        end
    end

    logic [GRANT_W:0] sel_in, sel_out;

    assign sel_in = {dly_out.raw_l & out_hit, out_grant};

    reg_delay #(
        .Width(GRANT_W + 1),
        .Depth(N_LAT)
    ) u_sel_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sel_in),
        .q    (sel_out)
    );

    always_comb begin
        odata = 8'h00;
        for (int unsigned k = 0; k < N_CL; k++) begin
            if (sel_out[GRANT_W] && sel_out[GRANT_W-1:0] == GRANT_W'(k)) begin
                odata = odata_i[8*k +: 8];
            end
        end
    end

    assign len_o    = dly_out.len;
    assign idata_o  = dly_out.data;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_udp_client_mux.sv
// Directed plus randomized bench for udp_client_mux against a packet-level reference model.
// Every cycle compares delayed stream, per-client gating, return data and counters.
module tb_udp_client_mux;

    localparam int N_CL = 4;
    localparam int NLAT = 2;
    localparam int DLY  = 5;
    localparam int MAXC = 8192;

    logic              clk;
    logic              rst_n;
    logic [10:0]       len_c;
    logic [7:0]        idata;
    logic              raw_l;
    logic              raw_s;
    logic [N_CL-1:0]   client_en;
    logic [7:0]        odata;
    logic [10:0]       len_o;
    logic [7:0]        idata_o;
    logic [N_CL-1:0]   raw_l_o;
    logic [N_CL-1:0]   raw_s_o;
    logic [8*N_CL-1:0] odata_i;
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;

    udp_client_mux #(
        .N_CL     (N_CL),
        .PORT_BASE(16'd3000),
        .N_LAT    (NLAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .len_c    (len_c),
        .idata    (idata),
        .raw_l    (raw_l),
        .raw_s    (raw_s),
        .client_en(client_en),
        .odata    (odata),
        .len_o    (len_o),
        .idata_o  (idata_o),
        .raw_l_o  (raw_l_o),
        .raw_s_o  (raw_s_o),
        .odata_i  (odata_i),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus history (st_data) and effective history after reset clearing (e_*).
    logic [7:0]  st_data [MAXC];
    logic [7:0]  e_data  [MAXC];
    logic [10:0] e_len   [MAXC];
    logic        e_rl    [MAXC];
    logic        e_rs    [MAXC];
    int          out_g   [MAXC];
    int          ret_g   [MAXC];

    int          cyc;
    int          n_checks;
    int          n_err;
    bit          prev_rl;
    bit          in_pkt;
    int          pkt_start;
    int          pkt_g;
    logic [15:0] m_port;
    int          m_hits;
    int          m_miss;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        int j, r;
        logic [N_CL-1:0] e_rlo, e_rso;
        logic [7:0] e_od;
        j = cyc - DLY;
        r = cyc - DLY - NLAT;
        e_rlo = '0;
        e_rso = '0;
        e_od  = 8'h00;
        for (int k = 0; k < N_CL; k++) begin
            if (j >= 0 && out_g[j] == k) begin
                e_rlo[k] = e_rl[j];
                e_rso[k] = e_rs[j];
            end
        end
        if (r >= 0 && ret_g[r] >= 0)
            e_od = st_data[r] ^ (8'hA0 + 8'(ret_g[r]));
        chk("idata_o", 16'(idata_o), (j >= 0) ? 16'(e_data[j]) : 16'h0);
        chk("len_o", 16'(len_o), (j >= 0) ? 16'(e_len[j]) : 16'h0);
        chk("raw_l_o", 16'(raw_l_o), 16'(e_rlo));
        chk("raw_s_o", 16'(raw_s_o), 16'(e_rso));
        chk("odata", 16'(odata), 16'(e_od));
        chk("hit_cnt", hit_cnt, 16'(m_hits));
        chk("miss_cnt", miss_cnt, 16'(m_miss));
    endtask

    // Packet-level reference: decision at header offset 4 from bytes 2/3 and current enables.
    task automatic model_update(input logic rl, input logic [7:0] d);
        int o;
        logic [15:0] idx;
        if (!in_pkt && rl && !prev_rl) begin
            in_pkt    = 1'b1;
            pkt_start = cyc;
            pkt_g     = -2;
        end
        if (in_pkt) begin
            o = cyc - pkt_start;
            if (o == 2) m_port[15:8] = d;
            if (o == 3) m_port[7:0] = d;
            if (o == 4) begin
                idx = m_port - 16'd3000;
                if (int'(idx) < N_CL && client_en[idx[1:0]]) begin
                    pkt_g = int'(idx);
                    if (m_hits < 65535) m_hits++;
                    for (int i = pkt_start; i < cyc; i++) begin
                        out_g[i] = pkt_g;
                        ret_g[i] = pkt_g;
                    end
                end else begin
                    pkt_g = -1;
                    if (m_miss < 65535) m_miss++;
                end
            end
            if (rl && pkt_g >= 0) begin
                out_g[cyc] = pkt_g;
                ret_g[cyc] = pkt_g;
            end
            if (!rl) in_pkt = 1'b0;
        end
        prev_rl = rl;
    endtask

    task automatic step(input logic rl, input logic rs, input logic [7:0] d, input logic [10:0] lc);
        raw_l = rl;
        raw_s = rs;
        idata = d;
        len_c = lc;
        st_data[cyc] = d;
        e_data[cyc]  = d;
        e_len[cyc]   = lc;
        e_rl[cyc]    = rl;
        e_rs[cyc]    = rs;
        out_g[cyc]   = -1;
        ret_g[cyc]   = -1;
        if (!rst_n) begin
            for (int i = cyc - DLY - NLAT; i <= cyc; i++) begin
                if (i >= 0) ret_g[i] = -1;
            end
            for (int i = cyc - DLY; i <= cyc; i++) begin
                if (i >= 0) begin
                    e_data[i] = 8'h00;
                    e_len[i]  = 11'h0;
                    e_rl[i]   = 1'b0;
                    e_rs[i]   = 1'b0;
                    out_g[i]  = -1;
                end
            end
            m_hits  = 0;
            m_miss  = 0;
            in_pkt  = 1'b0;
            prev_rl = 1'b1;
        end
        for (int k = 0; k < N_CL; k++) begin
            odata_i[8*k +: 8] = (cyc >= DLY + NLAT) ? (st_data[cyc-DLY-NLAT] ^ (8'hA0 + 8'(k)))
                                                    : (8'hA0 + 8'(k));
        end
        @(negedge clk);
        check_cycle();
        if (rst_n) model_update(rl, d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 11'($urandom));
    endtask

    task automatic send_pkt(input logic [15:0] port, input int plen, input int gap,
                            input int mid_at, input logic [N_CL-1:0] mid_en, input int rst_at);
        for (int o = 0; o < plen; o++) begin
            logic [7:0] b;
            if (o == 2)      b = port[15:8];
            else if (o == 3) b = port[7:0];
            else             b = 8'($urandom);
            if (o == mid_at) client_en = mid_en;
            if (o == rst_at) rst_n = 1'b0;
            if (rst_at >= 0 && o == rst_at + 3) rst_n = 1'b1;
            step(1'b1, logic'(o >= 8), b, 11'(plen - o));
        end
        rst_n = 1'b1;
        idle(gap);
    endtask

    int          r_len, r_gap, r_mid;
    logic [15:0] r_port;

    initial begin
        n_checks  = 0;
        n_err     = 0;
        cyc       = 0;
        prev_rl   = 1'b1;
        in_pkt    = 1'b0;
        pkt_start = 0;
        pkt_g     = -2;
        m_port    = 16'h0;
        m_hits    = 0;
        m_miss    = 0;
        for (int i = 0; i < MAXC; i++) begin
            st_data[i] = 8'h00;
            e_data[i]  = 8'h00;
            e_len[i]   = 11'h0;
            e_rl[i]    = 1'b0;
            e_rs[i]    = 1'b0;
            out_g[i]   = -1;
            ret_g[i]   = -1;
        end
        raw_l     = 1'b0;
        raw_s     = 1'b0;
        idata     = 8'h00;
        len_c     = 11'h0;
        odata_i   = '0;
        client_en = 4'b1111;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        idle(3);
        rst_n = 1'b1;
        idle(4);

        // Granted packet to client 1, then an out-of-range port.
        send_pkt(16'd3001, 20, 3, -1, 4'b1111, -1);
        send_pkt(16'd3007, 16, 3, -1, 4'b1111, -1);
        // Disabled client is skipped.
        client_en = 4'b1011;
        send_pkt(16'd3002, 16, 3, -1, 4'b1011, -1);
        // Enable drops mid-payload of a granted packet: no effect on that packet.
        client_en = 4'b1111;
        send_pkt(16'd3002, 24, 3, 12, 4'b1011, -1);
        client_en = 4'b1111;
        // Back-to-back with a one-cycle gap.
        send_pkt(16'd3000, 12, 1, -1, 4'b1111, -1);
        send_pkt(16'd3003, 12, 4, -1, 4'b1111, -1);
        // Runt packet.
        send_pkt(16'd3001, 3, 4, -1, 4'b1111, -1);
        // Reset mid-payload, then a normal packet.
        send_pkt(16'd3002, 20, 4, -1, 4'b1111, 12);
        send_pkt(16'd3000, 14, 4, -1, 4'b1111, -1);

        repeat (60) begin
            r_port    = 16'd2998 + 16'($urandom_range(0, 12));
            r_len     = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : $urandom_range(8, 30);
            r_gap     = $urandom_range(1, 3);
            r_mid     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            client_en = 4'($urandom);
            send_pkt(r_port, r_len, r_gap, r_mid, 4'($urandom), -1);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
